ics_sample_fetch: RTL

Sample fetch unit for the ICS2115 voice engine, sitting directly upstream of the 32-voice TDM mixer. It turns per-voice byte-address sample requests into 64-bit SDRAM reads through a one-line-per-voice cache. It extracts the addressed 8- or 16-bit sample and returns it as signed 16-bit PCM. Repeated reads within the same 8-byte line never touch SDRAM.

---
 rtl/ics_pkg.sv | 34 +++
 rtl/ics_ulaw_dec.sv | 23 ++
 rtl/ics_sample_fetch.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ics_pkg.sv
// Shared types and constants for the ICS2115 sample fetch unit.
package ics_pkg;

  localparam int unsigned AddrW      = 24;
  localparam int unsigned LineOffW   = 3;
  localparam int unsigned TagW       = AddrW - LineOffW;
  localparam int unsigned SdramAddrW = 29;
  localparam int unsigned LineW      = 64;

  typedef enum logic [1:0] {
    FMT_PCM8  = 2'b00,
    FMT_PCM16 = 2'b01,
    FMT_ULAW  = 2'b10,
    FMT_RSVD  = 2'b11
  } fmt_e;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StReq,
    StWait,
    StResp
  } state_e;

  // Little-endian byte lane n of a cache line.
  function automatic logic [7:0] sel_byte(input logic [LineW-1:0] word, input logic [2:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] sel_half(input logic [LineW-1:0] word, input logic [1:0] idx);
    return word[{idx, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/ics_ulaw_dec.sv
// Combinational G.711 mu-law to signed 16-bit PCM decoder.
module ics_ulaw_dec (
  input  logic [7:0]  code_i,
  output logic [15:0] sample_o
);

  logic [7:0]  u;
  logic [2:0]  expo;
  logic [3:0]  mant;
  logic [15:0] biased;
  logic [15:0] mag;

  always_comb begin
    u        = ~code_i;
    expo     = u[6:4];
    mant     = u[3:0];
    // Largest biased value is 252 << 7 = 32256, so 16 bits never overflow.
    biased   = ({9'd0, mant, 3'b000} + 16'd132) << expo;
    mag      = biased - 16'd132;
    sample_o = u[7] ? (~mag + 16'd1) : mag;
  end

endmodule

// File: rtl/ics_sample_fetch.sv
// Sample fetch unit: per-voice one-line cache in front of SDRAM, returns signed 16-bit PCM.
// Define ICS_ULAW_EN to decode format 10 as mu-law; otherwise it is treated as 8-bit linear.
module ics_sample_fetch
  import ics_pkg::*;
#(
  parameter int unsigned           VOICES     = 32,
  parameter logic [SdramAddrW-1:0] SDRAM_BASE = 29'h0800000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [$clog2(VOICES)-1:0]  req_voice_i,
  input  logic [AddrW-1:0]           req_addr_i,
  input  logic [1:0]                 req_fmt_i,
  input  logic                       flush_i,
  output logic                       rsp_valid_o,
  output logic [15:0]                rsp_sample_o,
  output logic                       sdram_rd_o,
  output logic [SdramAddrW-1:0]      sdram_addr_o,
  input  logic [LineW-1:0]           sdram_dout_i,
  input  logic                       sdram_busy_i,
  input  logic                       sdram_dout_ready_i
);

  localparam int unsigned VoiceW = $clog2(VOICES);

  state_e                  state_q;
  logic [VoiceW-1:0]       voice_q;
  logic [AddrW-1:0]        addr_q;
  fmt_e                    fmt_q;
  logic                    flush_pend_q;
  logic                    flush_pend_d;
  logic [VOICES-1:0]       valid_q;
  logic [TagW-1:0]         tag_q  [VOICES];
  logic [LineW-1:0]        line_q [VOICES];

  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic [15:0]             rsp_sample_q;
  logic                    sdram_rd_q;
  logic [SdramAddrW-1:0]   sdram_addr_q;

  logic [LineW-1:0]        src_word;
  logic [7:0]              sel_b;
  logic [15:0]             sel_h;
  logic [15:0]             pcm8;
  logic [15:0]             ulaw_sample;
  logic [15:0]             sample;
  logic                    hit;
  logic [SdramAddrW-1:0]   line_addr;

  // On a fill the sample is extracted straight from the returning SDRAM word.
  always_comb begin
    src_word = (state_q == StWait) ? sdram_dout_i : line_q[voice_q];
    sel_b    = sel_byte(src_word, addr_q[2:0]);
    sel_h    = sel_half(src_word, addr_q[2:1]);
    pcm8     = {sel_b, 8'h00};
    unique case (fmt_q)
      FMT_PCM8: sample = pcm8;
      FMT_ULAW: sample = ulaw_sample;
      default:  sample = sel_h;
    endcase
  end

`ifdef ICS_ULAW_EN
  ics_ulaw_dec u_ulaw_dec (
    .code_i   (sel_b),
    .sample_o (ulaw_sample)
  );
`else
  assign ulaw_sample = pcm8;
`endif

  always_comb begin
    hit          = valid_q[voice_q] && (tag_q[voice_q] == addr_q[AddrW-1:LineOffW]);
    line_addr    = SDRAM_BASE + {{(SdramAddrW - AddrW){1'b0}},
                                 addr_q[AddrW-1:LineOffW], {LineOffW{1'b0}}};
    // A pending flush is consumed by the first idle cycle it sees.
    flush_pend_d = flush_i || (flush_pend_q && (state_q != StIdle));
  end

  always_ff @(posedge clk) begin
    if (!reset && (state_q == StWait) && sdram_dout_ready_i) begin
      line_q[voice_q] <= sdram_dout_i;
      tag_q[voice_q]  <= addr_q[AddrW-1:LineOffW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      voice_q      <= '0;
      addr_q       <= '0;
      fmt_q        <= FMT_PCM8;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_sample_q <= '0;
      sdram_rd_q   <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      rsp_valid_q  <= 1'b0;
      flush_pend_q <= flush_pend_d;
      case (state_q)
        StIdle: begin
          if (flush_pend_q) begin
            valid_q     <= '0;
            req_ready_q <= ~flush_pend_d;
          end else if (req_valid_i && req_ready_q) begin
            voice_q     <= req_voice_i;
            addr_q      <= req_addr_i;
            fmt_q       <= fmt_e'(req_fmt_i);
            req_ready_q <= 1'b0;
            state_q     <= StLookup;
          end else begin
            req_ready_q <= ~flush_pend_d;
          end
        end
        StLookup: begin
          if (hit) begin
            rsp_sample_q <= sample;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else begin
            sdram_rd_q   <= 1'b1;
            sdram_addr_q <= line_addr;
            state_q      <= StReq;
          end
        end
        StReq: begin
          if (!sdram_busy_i) begin
            sdram_rd_q <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (sdram_dout_ready_i) begin
            valid_q[voice_q] <= 1'b1;
            rsp_sample_q     <= sample;
            rsp_valid_q      <= 1'b1;
            state_q          <= StResp;
          end
        end
        StResp: begin
          req_ready_q <= ~flush_pend_d;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_sample_o = rsp_sample_q;
  assign sdram_rd_o   = sdram_rd_q;
  assign sdram_addr_o = sdram_addr_q;

endmodule
